hazard_tracker: RTL and testbench

//   Pipeline-hazard tracker sitting directly downstream of the D-stage control decoder.

---
 rtl/hazard_tracker.sv | 116 +++++++++++
 tb/tb_hazard_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// Pipeline hazard tracker: keeps E/M/W destination records and derives the
// D-stage stall plus operand forwarding selects for the D, E and M muxes.
module hazard_tracker #(
    parameter logic [4:0] NO_USE_MIN = 5'd2,
    parameter logic [4:0] NO_WR_MIN  = 5'd3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       freeze,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rsT,
    input  logic [4:0] d_rtT,
    input  logic [4:0] d_T,
    input  logic [4:0] d_dst,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic [1:0] fwd_m_rt
);

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } rec_t;

    rec_t e_q, m_q, w_q, e_next;
    logic stall_rs, stall_rt;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // A stage blocks a reader when its result is not ready by the reader's use stage.
    function automatic logic hit(input rec_t s, input logic [4:0] r, input logic [4:0] tu);
        return (s.dst == r) && ({3'b000, s.tnew} > tu);
    endfunction

    function automatic logic [1:0] fwd_d(input logic [4:0] r, input rec_t e,
                                         input rec_t m, input rec_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (r == 5'd0)
            sel = 2'd0;
        else if (e.dst == r)
            sel = (e.tnew == 2'd0) ? 2'd1 : 2'd0;
        else if (m.dst == r)
            sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (w.dst == r)
            sel = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
        return sel;
    endfunction

    function automatic logic [1:0] fwd_e(input logic [4:0] r, input rec_t m, input rec_t w);
        logic [1:0] sel;
        sel = 2'd0;
        if (r == 5'd0)
            sel = 2'd0;
        else if (m.dst == r)
            sel = (m.tnew == 2'd0) ? 2'd2 : 2'd0;
        else if (w.dst == r)
            sel = (w.tnew == 2'd0) ? 2'd3 : 2'd0;
        return sel;
    endfunction

    always_comb begin
        e_next = '0;
        if (!stall) begin
            e_next.dst  = (d_T >= NO_WR_MIN) ? 5'd0 : d_dst;
            e_next.tnew = d_T[1:0];
            e_next.rs   = d_rs;
            e_next.rt   = d_rt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!freeze) begin
            e_q      <= e_next;
            m_q.dst  <= e_q.dst;
            m_q.tnew <= sat_dec(e_q.tnew);
            m_q.rs   <= e_q.rs;
            m_q.rt   <= e_q.rt;
            w_q.dst  <= m_q.dst;
            w_q.tnew <= sat_dec(m_q.tnew);
            w_q.rs   <= m_q.rs;
            w_q.rt   <= m_q.rt;
        end
    end

    // W always has tnew == 0, so only E and M can hold up D.
    always_comb begin
        stall_rs = (d_rs != 5'd0) && (d_rsT < NO_USE_MIN) &&
                   (hit(e_q, d_rs, d_rsT) || hit(m_q, d_rs, d_rsT));
        stall_rt = (d_rt != 5'd0) && (d_rtT < NO_USE_MIN) &&
                   (hit(e_q, d_rt, d_rtT) || hit(m_q, d_rt, d_rtT));
        stall    = stall_rs | stall_rt;
        fwd_d_rs = fwd_d(d_rs, e_q, m_q, w_q);
        fwd_d_rt = fwd_d(d_rt, e_q, m_q, w_q);
        fwd_e_rs = fwd_e(e_q.rs, m_q, w_q);
        fwd_e_rt = fwd_e(e_q.rt, m_q, w_q);
        fwd_m_rt = ((m_q.rt != 5'd0) && (w_q.dst == m_q.rt) && (w_q.tnew == 2'd0)) ? 2'd3 : 2'd0;
    end

    // Source fields kept in the records for visibility but not consumed downstream.
    logic unused_fields;
    assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt};

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: reference pipeline model feeds an expected-output
// queue, directed hazard scenarios plus randomised traffic.
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       freeze;
    logic [4:0] d_rs, d_rt, d_rsT, d_rtT, d_T, d_dst;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    always #5 clk = ~clk;

    hazard_tracker dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .freeze   (freeze),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_rsT    (d_rsT),
        .d_rtT    (d_rtT),
        .d_T      (d_T),
        .d_dst    (d_dst),
        .stall    (stall),
        .fwd_d_rs (fwd_d_rs),
        .fwd_d_rt (fwd_d_rt),
        .fwd_e_rs (fwd_e_rs),
        .fwd_e_rt (fwd_e_rt),
        .fwd_m_rt (fwd_m_rt)
    );

    typedef struct packed {
        logic       stall;
        logic [1:0] drs, drt, ers, ert, mrt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference records, index 0 = E, 1 = M, 2 = W.
    logic [4:0] md_dst[3];
    logic [1:0] md_tnew[3];
    logic [4:0] md_rs[3];
    logic [4:0] md_rt[3];

    logic       last_stall;
    logic [1:0] last_drs, last_drt, last_ers, last_ert, last_mrt;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            md_dst[s] = '0; md_tnew[s] = '0; md_rs[s] = '0; md_rt[s] = '0;
        end
    endtask

    function automatic logic [1:0] pick(input logic [4:0] r, input int first);
        for (int s = first; s < 3; s++)
            if (r != 5'd0 && md_dst[s] == r)
                return (md_tnew[s] == 2'd0) ? 2'(s + 1) : 2'd0;
        return 2'd0;
    endfunction

    function automatic exp_t model_out();
        exp_t o;
        logic [4:0] r, tu;
        o = '0;
        for (int k = 0; k < 2; k++) begin
            r  = (k == 0) ? d_rs  : d_rt;
            tu = (k == 0) ? d_rsT : d_rtT;
            if (r != 5'd0 && int'(tu) < 2)
                for (int s = 0; s < 2; s++)
                    if (md_dst[s] == r && int'(md_tnew[s]) > int'(tu))
                        o.stall = 1'b1;
        end
        o.drs = pick(d_rs, 0);
        o.drt = pick(d_rt, 0);
        o.ers = pick(md_rs[0], 1);
        o.ert = pick(md_rt[0], 1);
        o.mrt = pick(md_rt[1], 2);
        return o;
    endfunction

    task automatic model_adv();
        exp_t o;
        o = model_out();
        if (!freeze) begin
            for (int s = 2; s >= 1; s--) begin
                md_dst[s]  = md_dst[s-1];
                md_tnew[s] = (md_tnew[s-1] == 2'd0) ? 2'd0 : md_tnew[s-1] - 2'd1;
                md_rs[s]   = md_rs[s-1];
                md_rt[s]   = md_rt[s-1];
            end
            if (o.stall) begin
                md_dst[0] = '0; md_tnew[0] = '0; md_rs[0] = '0; md_rt[0] = '0;
            end else begin
                md_dst[0]  = (int'(d_T) >= 3) ? 5'd0 : d_dst;
                md_tnew[0] = d_T[1:0];
                md_rs[0]   = d_rs;
                md_rt[0]   = d_rt;
            end
        end
    endtask

    // One cycle: drive at posedge+1, queue expectation, compare at negedge, advance model.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rsT,
                        input logic [4:0] rtT, input logic [4:0] t, input logic [4:0] dst,
                        input logic frz);
        exp_t e;
        d_rs = rs; d_rt = rt; d_rsT = rsT; d_rtT = rtT; d_T = t; d_dst = dst; freeze = frz;
        #1;
        exp_q.push_back(model_out());
        @(negedge clk);
        last_stall = stall; last_drs = fwd_d_rs; last_drt = fwd_d_rt;
        last_ers = fwd_e_rs; last_ert = fwd_e_rt; last_mrt = fwd_m_rt;
        if (exp_q.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
        end else begin
            e = exp_q.pop_front();
            check("stall",    16'(stall),    16'(e.stall));
            check("fwd_d_rs", 16'(fwd_d_rs), 16'(e.drs));
            check("fwd_d_rt", 16'(fwd_d_rt), 16'(e.drt));
            check("fwd_e_rs", 16'(fwd_e_rs), 16'(e.ers));
            check("fwd_e_rt", 16'(fwd_e_rt), 16'(e.ert));
            check("fwd_m_rt", 16'(fwd_m_rt), 16'(e.mrt));
        end
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(5'd0, 5'd0, 5'd16, 5'd16, 5'd16, 5'd0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 16'(stall), 16'd0);
        check({tag, "_drs"}, 16'(fwd_d_rs), 16'd0);
        check({tag, "_drt"}, 16'(fwd_d_rt), 16'd0);
        check({tag, "_ers"}, 16'(fwd_e_rs), 16'd0);
        check({tag, "_ert"}, 16'(fwd_e_rt), 16'd0);
        check({tag, "_mrt"}, 16'(fwd_m_rt), 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] tuse_tab[4];
        logic [4:0] t_tab[5];
        tuse_tab = '{5'd0, 5'd1, 5'd2, 5'd16};
        t_tab    = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd16};

        reset_n = 1'b0; freeze = 1'b0;
        d_rs = '0; d_rt = '0; d_rsT = 5'd16; d_rtT = 5'd16; d_T = 5'd16; d_dst = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // lw $9 then add using $9 in E: one bubble, then W forwards into E.
        nops(3);
        step(5'd1, 5'd9, 5'd1, 5'd16, 5'd2, 5'd9, 1'b0);
        step(5'd9, 5'd10, 5'd1, 5'd1, 5'd1, 5'd11, 1'b0);
        check("s1_stall_first", 16'(last_stall), 16'd1);
        step(5'd9, 5'd10, 5'd1, 5'd1, 5'd1, 5'd11, 1'b0);
        check("s1_stall_second", 16'(last_stall), 16'd0);
        nops(1);
        check("s1_fwd_e_rs", 16'(last_ers), 16'd3);

        // lw $9 then beq on $9 in D: two stalls, then W forward.
        nops(3);
        step(5'd1, 5'd9, 5'd1, 5'd16, 5'd2, 5'd9, 1'b0);
        step(5'd9, 5'd8, 5'd0, 5'd0, 5'd16, 5'd0, 1'b0);
        check("s2_stall_1", 16'(last_stall), 16'd1);
        step(5'd9, 5'd8, 5'd0, 5'd0, 5'd16, 5'd0, 1'b0);
        check("s2_stall_2", 16'(last_stall), 16'd1);
        step(5'd9, 5'd8, 5'd0, 5'd0, 5'd16, 5'd0, 1'b0);
        check("s2_stall_3", 16'(last_stall), 16'd0);
        check("s2_fwd_d_rs", 16'(last_drs), 16'd3);

        // ori $5 then beq on rt=$5: one stall, then M forward.
        nops(3);
        step(5'd2, 5'd5, 5'd1, 5'd16, 5'd1, 5'd5, 1'b0);
        step(5'd0, 5'd5, 5'd16, 5'd0, 5'd16, 5'd0, 1'b0);
        check("s3_stall_1", 16'(last_stall), 16'd1);
        step(5'd0, 5'd5, 5'd16, 5'd0, 5'd16, 5'd0, 1'b0);
        check("s3_stall_2", 16'(last_stall), 16'd0);
        check("s3_fwd_d_rt", 16'(last_drt), 16'd2);

        // jal then jr $31: E result ready immediately.
        nops(3);
        step(5'd0, 5'd0, 5'd16, 5'd16, 5'd0, 5'd31, 1'b0);
        step(5'd31, 5'd0, 5'd0, 5'd16, 5'd16, 5'd0, 1'b0);
        check("s4_stall", 16'(last_stall), 16'd0);
        check("s4_fwd_d_rs", 16'(last_drs), 16'd1);

        // Write to $0 is never tracked.
        nops(3);
        step(5'd7, 5'd6, 5'd1, 5'd1, 5'd1, 5'd0, 1'b0);
        step(5'd0, 5'd0, 5'd0, 5'd0, 5'd16, 5'd0, 1'b0);
        check("s5a_stall", 16'(last_stall), 16'd0);
        check("s5a_drs", 16'(last_drs), 16'd0);
        check("s5a_drt", 16'(last_drt), 16'd0);
        check("s5a_mrt", 16'(last_mrt), 16'd0);

        // lw $3 then sw rt=$3: no stall, store data forwarded from W into M.
        nops(3);
        step(5'd1, 5'd3, 5'd1, 5'd16, 5'd2, 5'd3, 1'b0);
        step(5'd4, 5'd3, 5'd1, 5'd2, 5'd16, 5'd0, 1'b0);
        check("s5b_stall", 16'(last_stall), 16'd0);
        nops(1);
        check("s5b_mrt_early", 16'(last_mrt), 16'd0);
        nops(1);
        check("s5b_fwd_m_rt", 16'(last_mrt), 16'd3);

        // Freeze with lw in E: stall persists, then async reset clears everything.
        nops(3);
        step(5'd1, 5'd9, 5'd1, 5'd16, 5'd2, 5'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(5'd9, 5'd10, 5'd1, 5'd16, 5'd1, 5'd11, 1'b1);
            check("s6_frozen_stall", 16'(last_stall), 16'd1);
        end
        freeze = 1'b0;
        #1;
        check("s6_pre_reset_stall", 16'(stall), 16'd1);
        #1 reset_n = 1'b0;
        #1;
        check_all_zero("s6_reset");
        model_clear();
        exp_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Random traffic over a small register window to provoke frequent matches.
        for (int i = 0; i < 400; i++) begin
            step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 tuse_tab[$urandom_range(0, 3)], tuse_tab[$urandom_range(0, 3)],
                 t_tab[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
